// File: rtl/output_arbiter_node0_pkg.sv
// Shared types, field masks and helpers for the node-0 output arbiter.
package output_arbiter_node0_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam logic [15:0] STATE_MASK         = 16'h0F00;
    localparam logic [15:0] PAYLOAD_MASK       = 16'h00FF;
    localparam logic [3:0]  DEFAULT_READY_CODE = 4'h1;

    // Only the state field takes part in the readiness decision.
    function automatic logic is_ready(input logic [15:0] word, input logic [3:0] code);
        return (word & STATE_MASK) == {4'h0, code, 8'h00};
    endfunction

    function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
        if (int'(idx) >= n - 1)
            return 3'd0;
        else
            return idx + 3'd1;
    endfunction

endpackage

// File: rtl/output_arbiter_node0_rr_picker.sv
// Combinational round-robin search: first ready index at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int N_PERIPH = 2
) (
    input  logic [N_PERIPH-1:0] ready,
    input  logic [2:0]          rr_ptr,
    output logic                found,
    output logic [2:0]          index
);

    logic [2*N_PERIPH-1:0] doubled;
    logic [N_PERIPH-1:0]   rotated;
    logic [3:0]            offset;
    logic [3:0]            sum;

    // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set bit is the winner.
    always_comb begin
        doubled = {ready, ready};
        rotated = N_PERIPH'(doubled >> rr_ptr);
        found   = |rotated;
        offset  = 4'd0;
        for (int k = N_PERIPH - 1; k >= 0; k--) begin
            if (rotated[k])
                offset = 4'(k);
        end
        sum = {1'b0, rr_ptr} + offset;
        if (sum >= 4'(N_PERIPH))
            sum = sum - 4'(N_PERIPH);
        index = 3'(sum);
    end

endmodule

// File: rtl/output_arbiter_node0.sv
// Registered handshaked arbiter sharing node 0's output word between peripherals and next_task.
module output_arbiter_node0
    import output_arbiter_node0_pkg::*;
#(
    parameter int          N_PERIPH   = 2,
    parameter logic [3:0]  READY_CODE = DEFAULT_READY_CODE,
    parameter int          TIMEOUT    = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             next_task,
    input  logic [16*N_PERIPH-1:0] peripheral_bus,
    input  logic                   ack,
    output logic [15:0]            out,
    output logic                   out_valid,
    output logic                   out_is_periph,
    output logic [2:0]             grant_id,
    output logic [N_PERIPH-1:0]    periph_done,
    output logic                   timeout_err
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] PTR_INIT   = 3'(N_PERIPH - 1);

    arb_state_t state, state_next;

    logic [N_PERIPH-1:0] ready;
    logic                pick_found;
    logic [2:0]          pick_idx;
    logic [15:0]         pick_word;

    logic [7:0]          timer, timer_next;
    logic [2:0]          rr_ptr, rr_ptr_next;
    logic [15:0]         out_next;
    logic                valid_next;
    logic                is_periph_next;
    logic [2:0]          grant_next;
    logic [N_PERIPH-1:0] done_next;
    logic                err_next;

    logic                grant_ack;
    logic                grant_expire;

    always_comb begin
        ready     = '0;
        pick_word = 16'h0000;
        for (int i = 0; i < N_PERIPH; i++) begin
            ready[i] = is_ready(peripheral_bus[16*i +: 16], READY_CODE);
            if (3'(i) == pick_idx)
                pick_word = peripheral_bus[16*i +: 16];
        end
    end

    rr_picker #(
        .N_PERIPH (N_PERIPH)
    ) u_picker (
        .ready  (ready),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx)
    );

    // An ack on the last allowed cycle still counts as a normal completion.
    assign grant_ack    = (state == ST_GRANT) && ack;
    assign grant_expire = (state == ST_GRANT) && !ack && (timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            out           <= 16'h0000;
            out_valid     <= 1'b0;
            out_is_periph <= 1'b0;
            grant_id      <= 3'd0;
            periph_done   <= '0;
            timeout_err   <= 1'b0;
            rr_ptr        <= PTR_INIT;
            timer         <= 8'd0;
        end else begin
            state         <= state_next;
            out           <= out_next;
            out_valid     <= valid_next;
            out_is_periph <= is_periph_next;
            grant_id      <= grant_next;
            periph_done   <= done_next;
            timeout_err   <= err_next;
            rr_ptr        <= rr_ptr_next;
            timer         <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (pick_found) state_next = ST_GRANT;
            ST_GRANT:   if (grant_ack || grant_expire) state_next = ST_RELEASE;
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // RELEASE holds out and grant_id so the peripheral sees a stable word while it clears ready.
    always_comb begin
        out_next       = out;
        valid_next     = out_valid;
        is_periph_next = out_is_periph;
        grant_next     = grant_id;
        done_next      = '0;
        err_next       = 1'b0;
        rr_ptr_next    = rr_ptr;
        timer_next     = timer;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    out_next       = pick_word;
                    valid_next     = 1'b1;
                    is_periph_next = 1'b1;
                    grant_next     = pick_idx;
                    timer_next     = 8'd0;
                end else begin
                    out_next       = {8'h00, next_task} & PAYLOAD_MASK;
                    valid_next     = 1'b0;
                    is_periph_next = 1'b0;
                    grant_next     = 3'd0;
                end
            end
            ST_GRANT: begin
                if (grant_ack) begin
                    valid_next  = 1'b0;
                    rr_ptr_next = wrap_inc(grant_id, N_PERIPH);
                    for (int i = 0; i < N_PERIPH; i++)
                        done_next[i] = (3'(i) == grant_id);
                end else if (grant_expire) begin
                    valid_next  = 1'b0;
                    err_next    = 1'b1;
                    rr_ptr_next = wrap_inc(grant_id, N_PERIPH);
                end else begin
                    timer_next = timer + 8'd1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_output_arbiter_node0.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_output_arbiter_node0;

    localparam int N   = 2;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    next_task;
    logic [31:0]   peripheral_bus;
    logic          ack;
    logic [15:0]   out;
    logic          out_valid;
    logic          out_is_periph;
    logic [2:0]    grant_id;
    logic [N-1:0]  periph_done;
    logic          timeout_err;

    always #5 clk = ~clk;

    output_arbiter_node0 #(
        .N_PERIPH   (N),
        .READY_CODE (4'h1),
        .TIMEOUT    (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .next_task      (next_task),
        .peripheral_bus (peripheral_bus),
        .ack            (ack),
        .out            (out),
        .out_valid      (out_valid),
        .out_is_periph  (out_is_periph),
        .grant_id       (grant_id),
        .periph_done    (periph_done),
        .timeout_err    (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    // Model: which peripheral owns the output (-1 = none), how long it has waited, release pending.
    int          m_gnt;
    int          m_age;
    int          m_ptr;
    bit          m_rel;
    logic [15:0] e_out;
    logic        e_valid;
    logic        e_isp;
    logic [2:0]  e_gid;
    logic [N-1:0] e_done;
    logic        e_err;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep();
        int found;
        int idx;
        logic [3:0] field;
        if (rst) begin
            m_gnt = -1; m_age = 0; m_ptr = N - 1; m_rel = 0;
            e_out = 16'h0; e_valid = 0; e_isp = 0; e_gid = 0; e_done = '0; e_err = 0;
        end else begin
            e_done = '0;
            e_err  = 0;
            if (m_rel) begin
                m_rel = 0;
                m_gnt = -1;
            end else if (m_gnt >= 0) begin
                if (ack) begin
                    e_done[m_gnt] = 1'b1;
                    e_valid = 0;
                    m_rel   = 1;
                    m_ptr   = (m_gnt + 1) % N;
                end else if (m_age == TMO - 1) begin
                    e_err   = 1;
                    e_valid = 0;
                    m_rel   = 1;
                    m_ptr   = (m_gnt + 1) % N;
                end else begin
                    m_age++;
                end
            end else begin
                found = -1;
                for (int k = 0; k < N; k++) begin
                    idx   = (m_ptr + k) % N;
                    field = peripheral_bus[16*idx+8 +: 4];
                    if (found < 0 && field == 4'h1)
                        found = idx;
                end
                if (found >= 0) begin
                    e_out   = peripheral_bus[16*found +: 16];
                    e_valid = 1;
                    e_isp   = 1;
                    e_gid   = 3'(found);
                    m_gnt   = found;
                    m_age   = 0;
                end else begin
                    e_out   = {8'h00, next_task};
                    e_valid = 0;
                    e_isp   = 0;
                    e_gid   = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] nt, input logic [31:0] bus, input logic a);
        rst            = r;
        next_task      = nt;
        peripheral_bus = bus;
        ack            = a;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("out",           out,                  e_out);
        checkOutput("out_valid",     16'(out_valid),       16'(e_valid));
        checkOutput("out_is_periph", 16'(out_is_periph),   16'(e_isp));
        checkOutput("grant_id",      16'(grant_id),        16'(e_gid));
        checkOutput("periph_done",   16'(periph_done),     16'(e_done));
        checkOutput("timeout_err",   16'(timeout_err),     16'(e_err));
    endtask

    logic [2:0]  fair_order [4] = '{3'd1, 3'd0, 3'd1, 3'd0};
    logic [1:0]  fair_done  [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

    initial begin
        int valid_cnt;
        int err_cnt;
        int done_cnt;
        logic [15:0] w0;
        logic [15:0] w1;

        rst = 1'b1; next_task = 8'h00; peripheral_bus = '0; ack = 1'b0;

        // Reset then idle
        applyStimulus(1, 8'h2B, 32'h0, 0);
        applyStimulus(1, 8'h2B, 32'h0, 0);
        checkOutput("reset_out", out, 16'h0000);
        applyStimulus(0, 8'h2B, 32'h0, 0);
        checkOutput("idle_word", out, 16'h002B);

        // Single grant of p0, ack on second GRANT cycle
        applyStimulus(0, 8'h2B, {16'h0000, 16'h0142}, 0);
        checkOutput("single_out", out, 16'h0142);
        checkOutput("single_gid", 16'(grant_id), 16'h0000);
        applyStimulus(0, 8'h2B, {16'h0000, 16'h0142}, 0);
        applyStimulus(0, 8'h2B, {16'h0000, 16'h0142}, 1);
        checkOutput("single_done", 16'(periph_done), 16'h0001);
        applyStimulus(0, 8'h2B, 32'h0, 0);
        applyStimulus(0, 8'h2B, 32'h0, 0);
        checkOutput("single_back", out, 16'h002B);

        // Fairness between two always-ready peripherals
        for (int g = 0; g < 4; g++) begin
            applyStimulus(0, 8'h11, {16'h0122, 16'h0111}, 0);
            checkOutput("fair_gid", 16'(grant_id), 16'(fair_order[g]));
            applyStimulus(0, 8'h11, {16'h0122, 16'h0111}, 1);
            checkOutput("fair_done", 16'(periph_done), 16'(fair_done[g]));
            applyStimulus(0, 8'h11, {16'h0122, 16'h0111}, 0);
        end
        applyStimulus(0, 8'h11, 32'h0, 0);

        // Hold: word changes during GRANT, latched value stays
        applyStimulus(0, 8'h05, {16'h0123, 16'h0000}, 0);
        applyStimulus(0, 8'h05, {16'h0300, 16'h0000}, 0);
        checkOutput("hold_out", out, 16'h0123);
        applyStimulus(0, 8'h05, {16'h0300, 16'h0000}, 1);
        checkOutput("hold_done", 16'(periph_done), 16'h0002);
        checkOutput("hold_out2", out, 16'h0123);
        applyStimulus(0, 8'h05, 32'h0, 0);
        applyStimulus(0, 8'h05, 32'h0, 0);

        // Timeout: no ack ever
        valid_cnt = 0; err_cnt = 0; done_cnt = 0;
        applyStimulus(0, 8'h07, {16'h0000, 16'h0142}, 0);
        if (out_valid) valid_cnt++;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 8'h07, 32'h0, 0);
            if (out_valid) valid_cnt++;
            if (timeout_err) err_cnt++;
            if (periph_done != 0) done_cnt++;
        end
        checkOutput("tmo_valid_cycles", 16'(valid_cnt), 16'd4);
        checkOutput("tmo_err_pulses",   16'(err_cnt),   16'd1);
        checkOutput("tmo_done_pulses",  16'(done_cnt),  16'd0);
        applyStimulus(0, 8'h07, {16'h0155, 16'h0144}, 0);
        checkOutput("tmo_next_gid", 16'(grant_id), 16'd1);
        applyStimulus(0, 8'h07, {16'h0155, 16'h0144}, 1);
        applyStimulus(0, 8'h07, 32'h0, 0);
        applyStimulus(0, 8'h07, 32'h0, 0);

        // Ack on the final timeout cycle: completion wins
        applyStimulus(0, 8'h09, {16'h0155, 16'h0144}, 0);
        checkOutput("coinc_gid", 16'(grant_id), 16'd0);
        for (int c = 0; c < 3; c++)
            applyStimulus(0, 8'h09, 32'h0, 0);
        applyStimulus(0, 8'h09, 32'h0, 1);
        checkOutput("coinc_done", 16'(periph_done), 16'h0001);
        checkOutput("coinc_err",  16'(timeout_err), 16'h0000);
        applyStimulus(0, 8'h09, 32'h0, 0);
        applyStimulus(0, 8'h09, 32'h0, 0);

        // Reset in the middle of a grant
        applyStimulus(0, 8'h3C, {16'h0199, 16'h0000}, 0);
        applyStimulus(0, 8'h3C, {16'h0199, 16'h0000}, 0);
        applyStimulus(1, 8'h3C, {16'h0199, 16'h0000}, 1);
        checkOutput("mid_rst_out",   out,              16'h0000);
        checkOutput("mid_rst_valid", 16'(out_valid),   16'h0000);
        checkOutput("mid_rst_done",  16'(periph_done), 16'h0000);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            w0 = 16'($urandom);
            w1 = 16'($urandom);
            if ($urandom_range(1, 0) == 1) w0[11:8] = 4'h1;
            if ($urandom_range(1, 0) == 1) w1[11:8] = 4'h1;
            applyStimulus(($urandom_range(49, 0) == 0), 8'($urandom), {w1, w0},
                          ($urandom_range(9, 0) < 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
